frame_bank_scheduler: RTL and testbench

Triple-buffer bank scheduler between the gray capture stage and the frame-difference engine. Takes the synchronised capture stream (vsync high = frame valid, href high = line valid, 8-bit gray), assigns each complete frame to one of three frame-buffer banks, and generates buffer write strobes and addresses. Grants the difference reader a locked current/previous bank pair. Rejects frames with the wrong pixel count, and drops frames when no free bank exists.

---
 rtl/frame_bank_scheduler.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_scheduler.sv
// -----------------------------------------------------------------------------
// frame_bank_scheduler
//
// Triple-buffer bank scheduler between the gray capture stage and the
// frame-difference engine. Each complete capture frame is written into one of
// three frame-buffer banks; frames with a wrong pixel count are rejected and
// frames arriving while the reader holds its bank pair are discarded.
//
// Parameters
//   IMG_H, IMG_V  frame geometry (pixels per line, lines per frame)
//   ADDR_W        write address width, 2**ADDR_W >= IMG_H*IMG_V
//
// Ports
//   cmos_pclk     pixel clock
//   rst_n         asynchronous active-low reset
//   capture_en    level, enables frame acceptance
//   frame_vsync   frame valid (high during a frame)
//   frame_href    line valid
//   frame_data    8-bit gray pixel
//   wr_en/wr_bank/wr_addr/wr_data   registered frame-buffer write port
//   frame_ready   two committed frames available and reader not locked
//   rd_req        reader requests a bank pair (level)
//   rd_ack        one-cycle grant pulse
//   rd_cur_bank   newest committed bank (stable while locked)
//   rd_prev_bank  previous committed bank (stable while locked)
//   rd_done       one-cycle pulse releasing the reader lock
//   drop_cnt      dropped/rejected frame count
//
// Build option
//   FRAME_SCHED_STATS_EN  when defined, drop_cnt counts bad frames and commits
//                         discarded under lock (saturating at 255); otherwise
//                         drop_cnt is tied to zero.
// -----------------------------------------------------------------------------
module frame_bank_scheduler #(
  parameter int IMG_H  = 640,
  parameter int IMG_V  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              frame_vsync,
  input  logic              frame_href,
  input  logic [7:0]        frame_data,
  output logic              wr_en,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [1:0]        rd_cur_bank,
  output logic [1:0]        rd_prev_bank,
  input  logic              rd_done,
  output logic [7:0]        drop_cnt
);

  // One extra bit so the counter can hold the full frame size exactly.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_H * IMG_V);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q, vsync_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               ovf_q, ovf_d;
  logic               wr_en_q, wr_en_d;
  logic [1:0]         wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [1:0]         bank_wr_q, bank_wr_d;
  logic [1:0]         cur_q, cur_d;
  logic [1:0]         prev_q, prev_d;
  logic [1:0]         valid_q, valid_d;
  logic               lock_q, lock_d;
  logic               rd_ack_q, rd_ack_d;
  logic               frame_ready_q, frame_ready_d;

  logic               rise_s;
  logic               fall_s;
  logic               pix_s;
  logic               good_frame_s;

  assign rise_s       = frame_vsync & ~vsync_q;
  assign fall_s       = ~frame_vsync & vsync_q;
  assign pix_s        = frame_vsync & frame_href;
  assign good_frame_s = (pix_cnt_q == FRAME_PIX) & ~ovf_q;

  // Next-state logic: capture FSM, pixel write path, bank rotation, reader lock.
  always_comb begin
    state_d   = state_q;
    vsync_d   = frame_vsync;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_wr_d = bank_wr_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    valid_d   = valid_q;
    lock_d    = lock_q;
    rd_ack_d  = 1'b0;

    // Every frame start re-arms the pixel counter, whatever the state.
    if (rise_s) begin
      pix_cnt_d = {CNT_W{1'b0}};
      ovf_d     = 1'b0;
    end else begin
      pix_cnt_d = pix_cnt_q;
      ovf_d     = ovf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (capture_en) begin
          state_d = S_WAIT_VS;
        end else begin
          state_d = S_IDLE;
        end
      end

      // Only a fresh rise enters CAPTURE, so a frame already running is skipped.
      S_WAIT_VS: begin
        if (rise_s && capture_en) begin
          state_d = S_CAPTURE;
        end else if (!capture_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_VS;
        end
      end

      // capture_en is deliberately ignored here: a started frame always finishes.
      S_CAPTURE: begin
        if (fall_s) begin
          if (good_frame_s) begin
            state_d = S_COMMIT;
          end else begin
            // Bad frame: write bank is kept and simply overwritten next time.
            state_d = S_WAIT_VS;
          end
        end else if (pix_s) begin
          if (pix_cnt_q < FRAME_PIX) begin
            wr_en_d   = 1'b1;
            wr_bank_d = bank_wr_q;
            wr_addr_d = pix_cnt_q[ADDR_W-1:0];
            wr_data_d = frame_data;
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_COMMIT: begin
        if (!lock_q) begin
          prev_d    = cur_q;
          cur_d     = bank_wr_q;
          bank_wr_d = prev_q;
          if (valid_q != 2'd2) begin
            valid_d = valid_q + 2'd1;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          // Reader holds cur/prev: the frame just written is discarded.
          bank_wr_d = bank_wr_q;
        end
        if (capture_en) begin
          state_d = S_WAIT_VS;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Grant is held off during COMMIT so the reader sees the updated pair.
    if (lock_q) begin
      if (rd_done) begin
        lock_d = 1'b0;
      end else begin
        lock_d = 1'b1;
      end
    end else if (rd_req && frame_ready_q && (state_q != S_COMMIT)) begin
      lock_d   = 1'b1;
      rd_ack_d = 1'b1;
    end else begin
      lock_d = 1'b0;
    end

    frame_ready_d = (valid_d == 2'd2) & ~lock_d;
  end

  // State and output registers.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b0;
      pix_cnt_q     <= {CNT_W{1'b0}};
      ovf_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 2'd0;
      wr_addr_q     <= {ADDR_W{1'b0}};
      wr_data_q     <= 8'd0;
      bank_wr_q     <= 2'd0;
      cur_q         <= 2'd1;
      prev_q        <= 2'd2;
      valid_q       <= 2'd0;
      lock_q        <= 1'b0;
      rd_ack_q      <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      pix_cnt_q     <= pix_cnt_d;
      ovf_q         <= ovf_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      bank_wr_q     <= bank_wr_d;
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      valid_q       <= valid_d;
      lock_q        <= lock_d;
      rd_ack_q      <= rd_ack_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_ready  = frame_ready_q;
  assign rd_ack       = rd_ack_q;
  assign rd_cur_bank  = cur_q;
  assign rd_prev_bank = prev_q;

`ifdef FRAME_SCHED_STATS_EN
  logic       drop_inc_s;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_inc_s = ((state_q == S_CAPTURE) & fall_s & ~good_frame_s) |
                      ((state_q == S_COMMIT) & lock_q);

  // Saturating drop counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc_s && (drop_cnt_q != 8'd255)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
module tb_frame_bank_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
  localparam int N  = H * V;

  logic          cmos_pclk = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic          frame_vsync;
  logic          frame_href;
  logic [7:0]    frame_data;
  logic          wr_en;
  logic [1:0]    wr_bank;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_ready;
  logic          rd_req;
  logic          rd_ack;
  logic [1:0]    rd_cur_bank;
  logic [1:0]    rd_prev_bank;
  logic          rd_done;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 cmos_pclk = ~cmos_pclk;

  frame_bank_scheduler #(.IMG_H(H), .IMG_V(V), .ADDR_W(AW)) dut (
    .cmos_pclk    (cmos_pclk),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .frame_vsync  (frame_vsync),
    .frame_href   (frame_href),
    .frame_data   (frame_data),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_ready  (frame_ready),
    .rd_req       (rd_req),
    .rd_ack       (rd_ack),
    .rd_cur_bank  (rd_cur_bank),
    .rd_prev_bank (rd_prev_bank),
    .rd_done      (rd_done),
    .drop_cnt     (drop_cnt)
  );

  // Expected buffer writes, in order.
  typedef struct {
    logic [1:0]    bank;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Write-port monitor against the expected write queue.
  always @(negedge cmos_pclk) begin
    if (rst_n === 1'b1 && wr_en !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wr_en=%b bank %0d addr %0d, required no write",
                 wr_en, wr_bank, wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_en !== 1'b1 || wr_bank !== mon_e.bank || wr_addr !== mon_e.addr ||
            wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL write: got bank %0d addr %0d data %0h, required bank %0d addr %0d data %0h",
                   wr_bank, wr_addr, wr_data, mon_e.bank, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_drop(input int n);
`ifdef FRAME_SCHED_STATS_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge cmos_pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic apply_reset(input logic en);
    rst_n = 1'b0; capture_en = 1'b0; frame_vsync = 1'b0; frame_href = 1'b0;
    frame_data = 8'd0; rd_req = 1'b0; rd_done = 1'b0;
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    capture_en = en;
    idle(2);
  endtask

  // Drives one frame; returns right after the falling-vsync edge.
  task automatic send_frame(input int pix, input bit gaps, input bit exp_wr,
                            input logic [1:0] bank, input int en_at, input logic en_val);
    frame_vsync = 1'b1; frame_href = 1'b0;
    step();
    for (int i = 0; i < pix; i++) begin
      if (i == en_at) capture_en = en_val;
      if (gaps && $urandom_range(0, 3) == 0) begin
        frame_href = 1'b0;
        step();
      end
      frame_href = 1'b1;
      frame_data = 8'($urandom);
      if (exp_wr && i < N) exp_q.push_back('{bank, AW'(i), frame_data});
      step();
    end
    frame_href = 1'b0;
    step();
    frame_vsync = 1'b0;
    step();
  endtask

  task automatic check_drained(input string nm);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_state(input string nm, input logic [1:0] cur, input logic [1:0] prev,
                             input logic rdy, input int drops);
    chk({nm, "_cur"}, rd_cur_bank, cur);
    chk({nm, "_prev"}, rd_prev_bank, prev);
    chk({nm, "_ready"}, frame_ready, rdy);
    chk({nm, "_drop"}, drop_cnt, exp_drop(drops));
  endtask

  task automatic do_grant(input logic [1:0] cur, input logic [1:0] prev);
    int lat;
    bit got;
    lat = 0; got = 1'b0;
    rd_req = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      lat++;
      if (rd_ack === 1'b1) got = 1'b1;
    end
    rd_req = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_latency", lat, 1);
    chk("ack_cur", rd_cur_bank, cur);
    chk("ack_prev", rd_prev_bank, prev);
    step();
    chk("ack_pulse", rd_ack, 0);
  endtask

  task automatic do_release();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    step();
  endtask

  typedef struct {
    int         pix;
    bit         req;
    bit         done;
    logic [1:0] bank;
    logic [1:0] ack_cur;
    logic [1:0] ack_prev;
    logic [1:0] cur;
    logic [1:0] prev;
    logic       rdy;
    int         drops;
  } vec_t;
  vec_t tbl[6];

  // Behavioural bank model for the randomized phase.
  logic [1:0] m_wr, m_cur, m_prev, m_tmp;
  int         m_valid, m_drop;
  bit         m_lock;

  initial begin
    int op, pix;

    // rows: pixels, reader grant before, release before, write bank, expected pair at ack,
    //       cur, prev, ready and drops after the frame
    tbl[0] = '{7, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1};
    tbl[1] = '{9, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2};
    tbl[2] = '{8, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 2};
    tbl[3] = '{8, 0, 0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 1'b1, 2};
    tbl[4] = '{8, 1, 0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 3};
    tbl[5] = '{8, 0, 1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 1'b1, 3};

    // Reset values
    apply_reset(1'b1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ack", rd_ack, 0);
    check_state("rst", 2'd1, 2'd2, 1'b0, 0);

    // Table-driven frame sequence
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].done) do_release();
      if (tbl[r].req) do_grant(tbl[r].ack_cur, tbl[r].ack_prev);
      send_frame(tbl[r].pix, r[0], 1'b1, tbl[r].bank, -1, 1'b0);
      idle(3);
      check_drained($sformatf("tbl%0d_writes", r));
      check_state($sformatf("tbl%0d", r), tbl[r].cur, tbl[r].prev, tbl[r].rdy, tbl[r].drops);
    end

    // rd_req raised during the COMMIT that makes two frames valid
    apply_reset(1'b1);
    send_frame(8, 0, 1'b1, 2'd0, -1, 1'b0);
    idle(3);
    send_frame(8, 0, 1'b1, 2'd2, -1, 1'b0);
    rd_req = 1'b1;
    step();
    chk("commit_req_no_ack", rd_ack, 0);
    step();
    chk("commit_req_ack", rd_ack, 1);
    chk("commit_req_cur", rd_cur_bank, 2'd2);
    chk("commit_req_prev", rd_prev_bank, 2'd0);
    rd_req = 1'b0;
    idle(3);
    check_drained("commit_req_writes");

    // capture_en rising mid-frame, then falling mid-frame
    apply_reset(1'b0);
    send_frame(8, 0, 1'b0, 2'd0, 3, 1'b1);
    idle(3);
    check_drained("en_rise_writes");
    check_state("en_rise", 2'd1, 2'd2, 1'b0, 0);
    send_frame(8, 1, 1'b1, 2'd0, -1, 1'b0);
    idle(3);
    check_drained("en_ok_writes");
    send_frame(8, 0, 1'b1, 2'd2, 2, 1'b0);
    idle(3);
    check_drained("en_fall_writes");
    check_state("en_fall", 2'd0 + 2'd2, 2'd0, 1'b1, 0);
    send_frame(8, 0, 1'b0, 2'd0, -1, 1'b0);
    idle(3);
    check_drained("en_idle_writes");
    check_state("en_idle", 2'd2, 2'd0, 1'b1, 0);

    // Asynchronous reset in the middle of a frame
    apply_reset(1'b1);
    frame_vsync = 1'b1; frame_href = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      frame_href = 1'b1;
      frame_data = 8'($urandom);
      exp_q.push_back('{2'd0, AW'(i), frame_data});
      step();
    end
    frame_href = 1'b0;
    step();
    check_drained("rst_mid_pre_writes");
    frame_href = 1'b1;
    frame_data = 8'hA5;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_wr_addr", wr_addr, 0);
    chk("rst_mid_wr_data", wr_data, 0);
    check_state("rst_mid", 2'd1, 2'd2, 1'b0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    frame_href = 1'b0;
    step();
    frame_vsync = 1'b0;
    idle(4);
    check_drained("rst_mid_post_writes");
    check_state("rst_mid_after", 2'd1, 2'd2, 1'b0, 0);
    send_frame(8, 0, 1'b1, 2'd0, -1, 1'b0);
    idle(3);
    check_drained("rst_mid_next_writes");
    check_state("rst_mid_next", 2'd0, 2'd1, 1'b0, 0);

    // Randomized frames and reader activity against the model
    apply_reset(1'b1);
    m_wr = 2'd0; m_cur = 2'd1; m_prev = 2'd2; m_valid = 0; m_drop = 0; m_lock = 1'b0;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 6) begin
        pix = ($urandom_range(0, 1) == 0) ? N : (N - 2 + int'($urandom_range(0, 4)));
        send_frame(pix, 1'b1, 1'b1, m_wr, -1, 1'b0);
        idle(3);
        if (pix == N && !m_lock) begin
          m_tmp = m_prev; m_prev = m_cur; m_cur = m_wr; m_wr = m_tmp;
          m_valid = (m_valid < 2) ? m_valid + 1 : 2;
        end else begin
          m_drop++;
        end
        check_drained($sformatf("rnd%0d_writes", it));
      end else if (op <= 8) begin
        if (m_valid == 2 && !m_lock) begin
          do_grant(m_cur, m_prev);
          m_lock = 1'b1;
        end
      end else begin
        if (m_lock) begin
          do_release();
          m_lock = 1'b0;
        end
      end
      check_state($sformatf("rnd%0d", it), m_cur, m_prev, (m_valid == 2) && !m_lock, m_drop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
